// File: rtl/instr_fetch_reg.sv
// Instruction-fetch / instruction-register stage of the multi-cycle RV32I core.
// Issues one word read per fetch request and holds the instruction and its PC stable between fetches.
module instr_fetch_reg #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            fetch_start,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] old_pc,
  output logic [6:0]      op,
  output logic            opb5,
  output logic [2:0]      funct3,
  output logic            funct7b5,
  output logic            instr_valid,
  output logic            fetch_done,
  output logic            busy,
  output logic            misaligned,
  output logic            bus_error,
  output logic [1:0]      dbg_state
);

  // Memory port handshake: a request is taken when mem_req and mem_ready are
  // both high on a rising edge; mem_addr is held for as long as mem_req is high.
  // The response is the single cycle in which mem_rvalid is high after (or in
  // the same cycle as) the accepting edge.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic            mem_req_q, mem_req_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] old_pc_q, old_pc_d;
  logic            instr_valid_q, instr_valid_d;
  logic            fetch_done_q, fetch_done_d;
  logic            misaligned_q, misaligned_d;
  logic            bus_error_q, bus_error_d;

  logic aligned;
  logic accept;
  logic latch;
  logic timed_out;

  assign aligned = (pc_in[1:0] == 2'b00);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!flush && fetch_start && aligned) state_d = S_REQ;
      end
      S_REQ: begin
        if (flush)           state_d = S_IDLE;
        else if (mem_ready)  state_d = mem_rvalid ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid)            state_d = S_IDLE;
        else if (flush)            state_d = S_DRAIN;
        else if (cnt_q == CNT_LAST) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (mem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    accept    = (state_q == S_IDLE) && !flush && fetch_start && aligned;
    latch     = !flush && mem_rvalid &&
                (((state_q == S_REQ) && mem_ready) || (state_q == S_WAIT));
    timed_out = (state_q == S_WAIT) && !flush && !mem_rvalid && (cnt_q == CNT_LAST);

    cnt_d         = (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
    mem_addr_d    = accept ? pc_in : mem_addr_q;
    mem_req_d     = (state_d == S_REQ);
    instr_d       = latch ? mem_rdata[31:0] : instr_q;
    old_pc_d      = latch ? mem_addr_q : old_pc_q;
    instr_valid_d = flush ? 1'b0 : (latch ? 1'b1 : instr_valid_q);
    fetch_done_d  = latch;
    misaligned_d  = (state_q == S_IDLE) && !flush && fetch_start && !aligned;
    bus_error_d   = timed_out;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q         <= '0;
      mem_addr_q    <= '0;
      mem_req_q     <= 1'b0;
      instr_q       <= 32'h0000_0013;
      old_pc_q      <= RESET_PC;
      instr_valid_q <= 1'b0;
      fetch_done_q  <= 1'b0;
      misaligned_q  <= 1'b0;
      bus_error_q   <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_req_q     <= mem_req_d;
      instr_q       <= instr_d;
      old_pc_q      <= old_pc_d;
      instr_valid_q <= instr_valid_d;
      fetch_done_q  <= fetch_done_d;
      misaligned_q  <= misaligned_d;
      bus_error_q   <= bus_error_d;
    end
  end

  // Decode fields come from the held register so downstream decoders see a stable word.
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign old_pc      = old_pc_q;
  assign op          = instr_q[6:0];
  assign opb5        = instr_q[5];
  assign funct3      = instr_q[14:12];
  assign funct7b5    = instr_q[30];
  assign instr_valid = instr_valid_q;
  assign fetch_done  = fetch_done_q;
  assign busy        = (state_q != S_IDLE);
  assign misaligned  = misaligned_q;
  assign bus_error   = bus_error_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Directed bench for instr_fetch_reg: a per-cycle vector table plus hand-written
// sequences for timeout, stray responses and asynchronous reset mid-fetch.
module tb_instr_fetch_reg;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        fetch_start, flush, mem_ready, mem_rvalid;
  logic [31:0] pc_in, mem_rdata;
  logic        mem_req, opb5, funct7b5, instr_valid, fetch_done, busy, misaligned, bus_error;
  logic [31:0] mem_addr, instr, old_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  instr_fetch_reg #(.XLEN(32), .RESET_PC(32'h0), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn), .fetch_start(fetch_start), .pc_in(pc_in), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .instr(instr), .old_pc(old_pc), .op(op), .opb5(opb5),
    .funct3(funct3), .funct7b5(funct7b5), .instr_valid(instr_valid), .fetch_done(fetch_done),
    .busy(busy), .misaligned(misaligned), .bus_error(bus_error), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fs;
    logic [31:0] pc;
    logic        fl;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic        e_busy;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_iv;
    logic        e_fd;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fs, input logic [31:0] pc, input logic fl,
                       input logic rdy, input logic rv, input logic [31:0] rd);
    fetch_start = fs; pc_in = pc; flush = fl; mem_ready = rdy; mem_rvalid = rv; mem_rdata = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic fs, input logic [31:0] pc, input logic fl, input logic rdy,
                     input logic rv, input logic [31:0] rd, input logic e_req, input logic e_busy,
                     input logic [31:0] e_addr, input logic [31:0] e_instr, input logic [31:0] e_pc,
                     input logic e_iv, input logic e_fd, input logic e_mis);
    vec_t v;
    v.fs = fs; v.pc = pc; v.fl = fl; v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.e_req = e_req; v.e_busy = e_busy; v.e_addr = e_addr; v.e_instr = e_instr;
    v.e_pc = e_pc; v.e_iv = e_iv; v.e_fd = e_fd; v.e_mis = e_mis;
    vecs.push_back(v);
  endtask

  task automatic check_instr(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pc);
    logic [31:0] w;
    w = e_instr;
    chk({tag, ".instr"}, instr, e_instr);
    chk({tag, ".old_pc"}, old_pc, e_pc);
    chk({tag, ".op"}, {25'd0, op}, {25'd0, w[6:0]});
    chk({tag, ".opb5"}, {31'd0, opb5}, {31'd0, w[5]});
    chk({tag, ".funct3"}, {29'd0, funct3}, {29'd0, w[14:12]});
    chk({tag, ".funct7b5"}, {31'd0, funct7b5}, {31'd0, w[30]});
  endtask

  initial begin
    int n;
    bit seen;
    resetn = 1'b0;
    drive(0, 32'h0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.instr", instr, 32'h0000_0013);
    chk("reset.op", {25'd0, op}, 32'h13);
    chk("reset.old_pc", old_pc, 32'h0);
    chk("reset.instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("reset.mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset.mem_addr", mem_addr, 32'h0);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    //  fs pc        fl rdy rv rdata          req busy addr     instr          old_pc   iv fd mis
    add(0, 32'h0,   0, 0, 0, 32'h0,          0, 0, 32'h0,   32'h0000_0013, 32'h0,   0, 0, 0);
    add(1, 32'h40,  0, 0, 0, 32'h0,          1, 1, 32'h40,  32'h0000_0013, 32'h0,   0, 0, 0);
    add(0, 32'h0,   0, 1, 0, 32'h0,          0, 1, 32'h40,  32'h0000_0013, 32'h0,   0, 0, 0);
    add(0, 32'h0,   0, 0, 0, 32'h0,          0, 1, 32'h40,  32'h0000_0013, 32'h0,   0, 0, 0);
    add(0, 32'h0,   0, 0, 1, 32'h0050_0093,  0, 0, 32'h40,  32'h0050_0093, 32'h40,  1, 1, 0);
    add(0, 32'h0,   0, 0, 0, 32'h0,          0, 0, 32'h40,  32'h0050_0093, 32'h40,  1, 0, 0);
    add(1, 32'h80,  0, 0, 0, 32'h0,          1, 1, 32'h80,  32'h0050_0093, 32'h40,  1, 0, 0);
    add(0, 32'h0,   0, 1, 1, 32'h40B5_0533,  0, 0, 32'h80,  32'h40B5_0533, 32'h80,  1, 1, 0);
    add(1, 32'h42,  0, 0, 0, 32'h0,          0, 0, 32'h80,  32'h40B5_0533, 32'h80,  1, 0, 1);
    add(0, 32'h0,   0, 0, 0, 32'h0,          0, 0, 32'h80,  32'h40B5_0533, 32'h80,  1, 0, 0);
    add(1, 32'h100, 0, 0, 0, 32'h0,          1, 1, 32'h100, 32'h40B5_0533, 32'h80,  1, 0, 0);
    add(0, 32'h0,   0, 1, 0, 32'h0,          0, 1, 32'h100, 32'h40B5_0533, 32'h80,  1, 0, 0);
    add(0, 32'h0,   1, 0, 0, 32'h0,          0, 1, 32'h100, 32'h40B5_0533, 32'h80,  0, 0, 0);
    add(0, 32'h0,   0, 0, 1, 32'hDEAD_BEEF,  0, 0, 32'h100, 32'h40B5_0533, 32'h80,  0, 0, 0);
    add(1, 32'hC0,  0, 0, 0, 32'h0,          1, 1, 32'hC0,  32'h40B5_0533, 32'h80,  0, 0, 0);
    add(0, 32'h0,   0, 1, 1, 32'h00A0_0113,  0, 0, 32'hC0,  32'h00A0_0113, 32'hC0,  1, 1, 0);
    add(1, 32'h200, 0, 0, 0, 32'h0,          1, 1, 32'h200, 32'h00A0_0113, 32'hC0,  1, 0, 0);
    add(0, 32'h0,   1, 1, 0, 32'h0,          0, 0, 32'h200, 32'h00A0_0113, 32'hC0,  0, 0, 0);
    add(0, 32'h0,   0, 0, 1, 32'h1234_5678,  0, 0, 32'h200, 32'h00A0_0113, 32'hC0,  0, 0, 0);
    add(1, 32'h300, 0, 0, 0, 32'h0,          1, 1, 32'h300, 32'h00A0_0113, 32'hC0,  0, 0, 0);
    add(1, 32'h400, 0, 0, 0, 32'h0,          1, 1, 32'h300, 32'h00A0_0113, 32'hC0,  0, 0, 0);
    add(0, 32'h0,   0, 1, 1, 32'h0000_0513,  0, 0, 32'h300, 32'h0000_0513, 32'h300, 1, 1, 0);
    add(0, 32'h0,   0, 0, 0, 32'h0,          0, 0, 32'h300, 32'h0000_0513, 32'h300, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].fs, vecs[i].pc, vecs[i].fl, vecs[i].rdy, vecs[i].rv, vecs[i].rd);
      step();
      chk({tag, ".mem_req"}, {31'd0, mem_req}, {31'd0, vecs[i].e_req});
      chk({tag, ".busy"}, {31'd0, busy}, {31'd0, vecs[i].e_busy});
      chk({tag, ".mem_addr"}, mem_addr, vecs[i].e_addr);
      chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, vecs[i].e_iv});
      chk({tag, ".fetch_done"}, {31'd0, fetch_done}, {31'd0, vecs[i].e_fd});
      chk({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, vecs[i].e_mis});
      chk({tag, ".bus_error"}, {31'd0, bus_error}, 32'd0);
      check_instr(tag, vecs[i].e_instr, vecs[i].e_pc);
    end

    // Timeout: WAIT lasts TIMEOUT cycles, then one bus_error pulse.
    drive(1, 32'h500, 0, 0, 0, 32'h0);
    step();
    drive(0, 32'h0, 0, 1, 0, 32'h0);
    step();
    drive(0, 32'h0, 0, 0, 0, 32'h0);
    n = 0;
    seen = 0;
    for (int i = 1; i <= TIMEOUT + 4 && !seen; i++) begin
      step();
      if (bus_error === 1'b1) begin
        seen = 1;
        n = i;
      end
    end
    chk("timeout.seen", {31'd0, seen}, 32'd1);
    chk("timeout.cycles", n, TIMEOUT);
    chk("timeout.busy", {31'd0, busy}, 32'd0);
    check_instr("timeout", 32'h0000_0513, 32'h300);
    drive(0, 32'h0, 0, 0, 1, 32'hCAFE_F00D);
    step();
    chk("timeout.pulse_width", {31'd0, bus_error}, 32'd0);
    chk("stray.fetch_done", {31'd0, fetch_done}, 32'd0);
    check_instr("stray", 32'h0000_0513, 32'h300);

    // Asynchronous reset mid-fetch, then a late response must be ignored.
    drive(1, 32'h600, 0, 0, 0, 32'h0);
    step();
    drive(0, 32'h0, 0, 1, 0, 32'h0);
    step();
    chk("arst.pre_busy", {31'd0, busy}, 32'd1);
    drive(0, 32'h0, 0, 0, 0, 32'h0);
    #2 resetn = 1'b0;
    #1;
    chk("arst.busy", {31'd0, busy}, 32'd0);
    chk("arst.mem_addr", mem_addr, 32'h0);
    chk("arst.instr_valid", {31'd0, instr_valid}, 32'd0);
    check_instr("arst", 32'h0000_0013, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    drive(0, 32'h0, 0, 0, 1, 32'h1111_1111);
    step();
    chk("arst.late_fd", {31'd0, fetch_done}, 32'd0);
    check_instr("arst.late", 32'h0000_0013, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
